fft_frame_scheduler: RTL and testbench

FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

---
 rtl/fft_frame_scheduler_pkg.sv | 12 +
 rtl/fft_tag_fifo.sv | 57 +++++
 rtl/fft_frame_scheduler.sv | 129 ++++++++++++
 tb/tb_fft_frame_scheduler.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and widths for the two-channel FFT frame scheduler.
package fft_frame_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam int CNT_W = 10;
  localparam int CH_W  = 1;

endpackage

// File: rtl/fft_tag_fifo.sv
// Small synchronous FIFO carrying the source channel of each frame in flight
// through the FFT. Push and pop together are accepted when full or empty.
module fft_tag_fifo
  import fft_frame_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [CH_W-1:0] din,
  output logic [CH_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CH_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_wr;
  logic            do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = push && (!full || pop);
  assign do_rd = pop && (!empty || push);
  // When empty, the incoming tag is the head, so a same-cycle pop consumes it.
  assign dout  = empty ? din : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Round-robin loader of N-sample frames from two channels into an FFT chain,
// with per-frame channel tags re-attached to the registered FFT output.
module fft_frame_scheduler
  import fft_frame_scheduler_pkg::*;
#(
  parameter int N         = 256,
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  output logic [1:0]  gnt_o,
  input  logic [1:0]  s_valid_i,
  input  logic [31:0] s0_re_i,
  input  logic [31:0] s0_im_i,
  input  logic [31:0] s1_re_i,
  input  logic [31:0] s1_im_i,
  output logic        fft_start_o,
  output logic        fft_dready_o,
  output logic [31:0] fft_re_o,
  output logic [31:0] fft_im_o,
  input  logic        fft_busy_i,
  input  logic        fft_ready_i,
  input  logic        fft_done_i,
  input  logic [31:0] fft_re_i,
  input  logic [31:0] fft_im_i,
  output logic        fft_dl_busy_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  output logic        out_ch_o,
  output logic [31:0] out_re_o,
  output logic [31:0] out_im_o,
  input  logic        out_busy_i,
  output logic        err_o
);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0] gch;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] pick;
  logic [1:0]      gnt_q;
  logic            accept;
  logic            last_accept;
  logic            start_frame;
  logic [CH_W-1:0] tag_head;
  logic            tag_full;
  logic            tag_empty;

  // rr_ptr names the channel that has priority at the next frame start.
  assign pick        = req_i[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign start_frame = (state == IDLE) && (|req_i) && !fft_busy_i && !tag_full;
  assign accept      = (state == LOAD) && s_valid_i[gch] && !rst;
  assign last_accept = accept && (cnt == CNT_W'(N - 1));

  assign gnt_o         = rst ? 2'b00 : gnt_q;
  assign fft_dready_o  = accept;
  assign fft_start_o   = accept && (cnt == '0);
  assign fft_re_o      = accept ? ((gch == 1'b1) ? s1_re_i : s0_re_i) : '0;
  assign fft_im_o      = accept ? ((gch == 1'b1) ? s1_im_i : s0_im_i) : '0;
  assign fft_dl_busy_o = out_busy_i;

  fft_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (last_accept),
    .pop  (fft_done_i),
    .din  (gch),
    .dout (tag_head),
    .full (tag_full),
    .empty(tag_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      gch    <= '0;
      rr_ptr <= '0;
      gnt_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start_frame) begin
            state  <= LOAD;
            cnt    <= '0;
            gch    <= pick;
            rr_ptr <= ~pick;
            gnt_q  <= (pick == 1'b1) ? 2'b10 : 2'b01;
          end
        end
        LOAD: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (last_accept) begin
              state <= IDLE;
              gnt_q <= 2'b00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A done with no tag in flight reports channel 0 and latches the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_ch_o    <= 1'b0;
      out_re_o    <= '0;
      out_im_o    <= '0;
      err_o       <= 1'b0;
    end else begin
      out_valid_o <= fft_ready_i;
      out_last_o  <= fft_done_i;
      out_re_o    <= fft_re_i;
      out_im_o    <= fft_im_i;
      out_ch_o    <= (tag_empty && !last_accept) ? 1'b0 : tag_head;
      err_o       <= err_o
                     || (fft_done_i && tag_empty && !last_accept)
                     || (fft_ready_i && out_busy_i);
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench for fft_frame_scheduler against a queue-based model of
// round-robin grants and in-flight frame tags.
module tb_fft_frame_scheduler;

  localparam int N         = 256;
  localparam int TAG_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i, gnt_o, s_valid_i;
  logic [31:0] s0_re_i, s0_im_i, s1_re_i, s1_im_i;
  logic        fft_start_o, fft_dready_o;
  logic [31:0] fft_re_o, fft_im_o;
  logic        fft_busy_i, fft_ready_i, fft_done_i;
  logic [31:0] fft_re_i, fft_im_i;
  logic        fft_dl_busy_o, out_valid_o, out_last_o, out_ch_o;
  logic [31:0] out_re_o, out_im_o;
  logic        out_busy_i, err_o;

  int compared   = 0;
  int mismatched = 0;
  int q_tag[$];
  int rr_ptr     = 0;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.N(N), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .s_valid_i(s_valid_i),
    .s0_re_i(s0_re_i), .s0_im_i(s0_im_i), .s1_re_i(s1_re_i), .s1_im_i(s1_im_i),
    .fft_start_o(fft_start_o), .fft_dready_o(fft_dready_o),
    .fft_re_o(fft_re_o), .fft_im_o(fft_im_o), .fft_busy_i(fft_busy_i),
    .fft_ready_i(fft_ready_i), .fft_done_i(fft_done_i),
    .fft_re_i(fft_re_i), .fft_im_i(fft_im_i), .fft_dl_busy_o(fft_dl_busy_o),
    .out_valid_o(out_valid_o), .out_last_o(out_last_o), .out_ch_o(out_ch_o),
    .out_re_o(out_re_o), .out_im_o(out_im_o), .out_busy_i(out_busy_i), .err_o(err_o)
  );

  // Round-robin reference: the priority channel wins if it asks, otherwise the other.
  function automatic int model_pick(input logic [1:0] req);
    int ch;
    ch = req[rr_ptr] ? rr_ptr : 1 - rr_ptr;
    rr_ptr = 1 - ch;
    return ch;
  endfunction

  task automatic drive_idle();
    req_i = 2'b00; s_valid_i = 2'b00;
    s0_re_i = '0; s0_im_i = '0; s1_re_i = '0; s1_im_i = '0;
    fft_busy_i = 1'b0; fft_ready_i = 1'b0; fft_done_i = 1'b0;
    fft_re_i = '0; fft_im_i = '0; out_busy_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive_idle();
    @(negedge clk); #1;
    rst = 1'b0;
    q_tag.delete();
    rr_ptr = 0;
  endtask

  // Waits for a grant, then streams N samples on the granted channel.
  task automatic load_frame(input int gap_at, input int gap_len, input bit keep_req,
                            output int waited);
    int ch, idx, gap_left, strobes, starts;
    logic [1:0]  req_seen, exp_gnt;
    logic [31:0] exp_re, exp_im;
    req_seen = req_i;
    waited = 0;
    while (gnt_o == 2'b00 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    ch = model_pick(req_seen);
    exp_gnt = (ch == 1) ? 2'b10 : 2'b01;
    compared++;
    if (gnt_o !== exp_gnt) begin
      mismatched++;
      $display("[TB] FAIL grant: got %b want %b after %0d cycles", gnt_o, exp_gnt, waited);
    end
    if (!keep_req) req_i = 2'b00;
    idx = 0; gap_left = gap_len; strobes = 0; starts = 0;
    while (idx < N) begin
      s0_re_i = $urandom; s0_im_i = $urandom; s1_re_i = $urandom; s1_im_i = $urandom;
      s_valid_i = 2'($urandom);
      if (idx == gap_at && gap_left > 0) begin
        s_valid_i[ch] = 1'b0;
        gap_left--;
        #1;
        compared++;
        if ({fft_dready_o, fft_start_o, fft_re_o, fft_im_o} !== 66'b0) begin
          mismatched++;
          $display("[TB] FAIL gap_strobe: got dready=%b re=%h want 0", fft_dready_o, fft_re_o);
        end
        compared++;
        if (int'(dut.cnt) != idx) begin
          mismatched++;
          $display("[TB] FAIL gap_count: got %0d want %0d", dut.cnt, idx);
        end
      end else begin
        s_valid_i[ch] = 1'b1;
        exp_re = (ch == 1) ? s1_re_i : s0_re_i;
        exp_im = (ch == 1) ? s1_im_i : s0_im_i;
        #1;
        compared++;
        if ({fft_dready_o, fft_start_o, fft_re_o, fft_im_o} !== {1'b1, idx == 0, exp_re, exp_im}) begin
          mismatched++;
          $display("[TB] FAIL load_sample %0d: got dv=%b st=%b %h/%h want 1 %b %h/%h", idx,
                   fft_dready_o, fft_start_o, fft_re_o, fft_im_o, idx == 0, exp_re, exp_im);
        end
        idx++;
      end
      strobes += int'(fft_dready_o);
      starts  += int'(fft_start_o);
      compared++;
      if (gnt_o !== exp_gnt) begin
        mismatched++;
        $display("[TB] FAIL grant_hold: got %b want %b", gnt_o, exp_gnt);
      end
      @(negedge clk); #1;
    end
    s_valid_i = 2'b00;
    compared++;
    if (gnt_o !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL grant_release: got %b want 00", gnt_o);
    end
    compared++;
    if (strobes != N || starts != 1) begin
      mismatched++;
      $display("[TB] FAIL frame_counts: got %0d strobes %0d starts want %0d and 1", strobes, starts, N);
    end
    q_tag.push_back(ch);
  endtask

  // Plays one FFT output frame and checks the registered output and its tag.
  task automatic emit_frame();
    int tag;
    logic [31:0] re, im;
    tag = (q_tag.size() > 0) ? q_tag[0] : 0;
    for (int i = 0; i < N; i++) begin
      re = $urandom; im = $urandom;
      fft_ready_i = 1'b1; fft_re_i = re; fft_im_i = im; fft_done_i = (i == N - 1);
      @(negedge clk); #1;
      compared++;
      if ({out_valid_o, out_last_o, out_ch_o, out_re_o, out_im_o} !==
          {1'b1, i == N - 1, 1'(tag), re, im}) begin
        mismatched++;
        $display("[TB] FAIL out_sample %0d: got v=%b l=%b ch=%b %h/%h want 1 %b %0d %h/%h", i,
                 out_valid_o, out_last_o, out_ch_o, out_re_o, out_im_o, i == N - 1, tag, re, im);
      end
    end
    fft_ready_i = 1'b0; fft_done_i = 1'b0; fft_re_i = '0; fft_im_i = '0;
    if (q_tag.size() > 0) tag = q_tag.pop_front();
    @(negedge clk); #1;
    compared++;
    if (out_valid_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL out_idle: got %b want 0", out_valid_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    out_busy_i = 1'b1;
    #1;
    compared++;
    if ({gnt_o, fft_dready_o, fft_start_o} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_comb: got %b want 0000", {gnt_o, fft_dready_o, fft_start_o});
    end
    compared++;
    if (fft_dl_busy_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL dl_busy_high: got %b want 1", fft_dl_busy_o);
    end
    @(negedge clk); #1;
    compared++;
    if ({out_valid_o, out_last_o, out_ch_o, err_o, out_re_o, out_im_o} !== 68'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_regs: got v=%b l=%b ch=%b e=%b want 0",
               out_valid_o, out_last_o, out_ch_o, err_o);
    end
    out_busy_i = 1'b0;
    #1;
    compared++;
    if (fft_dl_busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dl_busy_low: got %b want 0", fft_dl_busy_o);
    end
    rst = 1'b0;
    q_tag.delete();
    rr_ptr = 0;
    @(negedge clk); #1;
    compared++;
    if ({gnt_o, err_o} !== 3'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset: got gnt=%b err=%b want 0", gnt_o, err_o);
    end
  endtask

  task automatic test_single_ch0();
    int w;
    req_i = 2'b01;
    load_frame(-1, 0, 1'b0, w);
    emit_frame();
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_err: got %b want 0", err_o);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    req_i = 2'b11;
    fork
      begin
        int w;
        for (int f = 0; f < 6; f++) begin
          load_frame(-1, 0, f < 5, w);
          if (f > 0) begin
            compared++;
            if (w != 1) begin
              mismatched++;
              $display("[TB] FAIL frame_spacing: got %0d idle cycles want 1", w);
            end
          end
        end
      end
      begin
        int waits;
        for (int f = 0; f < 6; f++) begin
          waits = 0;
          while (q_tag.size() == 0 && waits < 2 * N) begin
            @(negedge clk); #1;
            waits++;
          end
          compared++;
          if (q_tag.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL tag_wait: got no frame after %0d cycles want one", waits);
          end
          repeat ($urandom_range(1, 3)) @(negedge clk);
          #1;
          emit_frame();
        end
      end
    join
  endtask

  task automatic test_busy();
    int w;
    req_i = 2'b01;
    fft_busy_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      compared++;
      if (gnt_o !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL busy_hold %0d: got %b want 00", i, gnt_o);
      end
    end
    fft_busy_i = 1'b0;
    @(negedge clk); #1;
    compared++;
    if (gnt_o !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL busy_release: got %b want 01", gnt_o);
    end
    load_frame(-1, 0, 1'b0, w);
    emit_frame();
  endtask

  task automatic test_gap();
    int w;
    req_i = 2'b10;
    load_frame(100, 10, 1'b0, w);
    emit_frame();
  endtask

  task automatic test_fifo_full();
    int w;
    req_i = 2'b01;
    for (int f = 0; f < 4; f++) load_frame(-1, 0, 1'b1, w);
    compared++;
    if (int'(dut.u_tag_fifo.count) != 4) begin
      mismatched++;
      $display("[TB] FAIL fifo_count_full: got %0d want 4", dut.u_tag_fifo.count);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      compared++;
      if (gnt_o !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL full_block %0d: got %b want 00", i, gnt_o);
      end
    end
    emit_frame();
    compared++;
    if (gnt_o !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL grant_after_pop: got %b want 01", gnt_o);
    end
    // Last input sample and FFT done land on the same edge.
    fork
      load_frame(-1, 0, 1'b0, w);
      emit_frame();
    join
    compared++;
    if (int'(dut.u_tag_fifo.count) != 3 || q_tag.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL fifo_push_pop: got %0d want 3", dut.u_tag_fifo.count);
    end
    repeat (3) emit_frame();
    compared++;
    if (int'(dut.u_tag_fifo.count) != 0 || err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fifo_drain: got count=%0d err=%b want 0 0", dut.u_tag_fifo.count, err_o);
    end
  endtask

  task automatic test_error_reset();
    fft_done_i = 1'b1;
    @(negedge clk); #1;
    fft_done_i = 1'b0;
    compared++;
    if ({err_o, out_ch_o, out_last_o} !== 3'b101) begin
      mismatched++;
      $display("[TB] FAIL empty_done: got err=%b ch=%b last=%b want 1 0 1", err_o, out_ch_o, out_last_o);
    end
    repeat (5) begin
      @(negedge clk); #1;
      compared++;
      if (err_o !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL err_sticky: got %b want 1", err_o);
      end
    end
    apply_reset();
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_clear: got %b want 0", err_o);
    end
    out_busy_i = 1'b1; fft_ready_i = 1'b1;
    @(negedge clk); #1;
    out_busy_i = 1'b0; fft_ready_i = 1'b0;
    compared++;
    if ({err_o, out_valid_o} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL busy_err: got err=%b v=%b want 1 1", err_o, out_valid_o);
    end
    apply_reset();
    req_i = 2'b01;
    @(negedge clk); #1;
    compared++;
    if (gnt_o !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL abort_grant: got %b want 01", gnt_o);
    end
    req_i = 2'b00;
    for (int i = 0; i < 100; i++) begin
      s_valid_i = 2'b01; s0_re_i = $urandom; s0_im_i = $urandom;
      @(negedge clk); #1;
    end
    compared++;
    if (int'(dut.cnt) != 100) begin
      mismatched++;
      $display("[TB] FAIL abort_count: got %0d want 100", dut.cnt);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({gnt_o, fft_dready_o, fft_start_o} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_comb: got gnt=%b dv=%b st=%b want 0", gnt_o, fft_dready_o, fft_start_o);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    compared++;
    if ({gnt_o, fft_dready_o, fft_start_o, out_valid_o, out_last_o, out_ch_o, err_o, out_re_o, out_im_o}
        !== 72'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_outputs: got gnt=%b dv=%b v=%b err=%b want 0",
               gnt_o, fft_dready_o, out_valid_o, err_o);
    end
    compared++;
    if (int'(dut.u_tag_fifo.count) != 0 || dut.u_tag_fifo.empty !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL abort_fifo: got count=%0d want 0", dut.u_tag_fifo.count);
    end
    q_tag.delete();
    rr_ptr = 0;
    s_valid_i = 2'b00;
    req_i = 2'b11;
    @(negedge clk); #1;
    compared++;
    if (gnt_o !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL rr_after_reset: got %b want 01", gnt_o);
    end
    apply_reset();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_ch0();
    test_alternate();
    test_busy();
    test_gap();
    test_fifo_full();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
